// File: rtl/axi_rr_arbiter_pkg.sv
// Shared definitions for the NUM_M-to-1 AXI round-robin arbiter: channel field
// widths, burst/response encodings, FSM state encodings and a one-hot helper.
package axi_rr_arbiter_pkg;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // One-hot state encodings, one FSM per direction.
    typedef enum logic [2:0] {
        RD_IDLE = 3'b001,
        RD_ADDR = 3'b010,
        RD_DATA = 3'b100
    } rd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE = 3'b001,
        WR_ADDR = 3'b010,
        WR_RESP = 3'b100
    } wr_state_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic int unsigned onehot_idx(input logic [7:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// AXI bundle carrying N packed ports; port k occupies slice [k*W +: W].
// The master modport drives requests, the slave modport answers them.
interface axi_rr_arbiter_if #(
    parameter int N      = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import axi_rr_arbiter_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    logic [N*ID_W-1:0]    arid;
    logic [N*ADDR_W-1:0]  araddr;
    logic [N*LEN_W-1:0]   arlen;
    logic [N*SIZE_W-1:0]  arsize;
    logic [N*BURST_W-1:0] arburst;
    logic [N-1:0]         arvalid;
    logic [N-1:0]         arready;

    logic [N*ID_W-1:0]    rid;
    logic [N*DATA_W-1:0]  rdata;
    logic [N*RESP_W-1:0]  rresp;
    logic [N-1:0]         rlast;
    logic [N-1:0]         rvalid;
    logic [N-1:0]         rready;

    logic [N*ID_W-1:0]    awid;
    logic [N*ADDR_W-1:0]  awaddr;
    logic [N*LEN_W-1:0]   awlen;
    logic [N*SIZE_W-1:0]  awsize;
    logic [N*BURST_W-1:0] awburst;
    logic [N-1:0]         awvalid;
    logic [N-1:0]         awready;

    logic [N*DATA_W-1:0]  wdata;
    logic [N*STRB_W-1:0]  wstrb;
    logic [N-1:0]         wlast;
    logic [N-1:0]         wvalid;
    logic [N-1:0]         wready;

    logic [N*ID_W-1:0]    bid;
    logic [N*RESP_W-1:0]  bresp;
    logic [N-1:0]         bvalid;
    logic [N-1:0]         bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_rr_arbiter_rr_arb.sv
// Round-robin picker: one-hot grant of the first requester at or after the
// pointer (cyclic). The pointer moves past the served index only on completion.
module rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [N-1:0]     gnt
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Cyclic priority search starting at the pointer.
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
            end
        end
    end

    // Pointer moves to the master after the one just served, wrapping at N.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (adv_idx == IDX_W'(N - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// NUM_M-master to single-slave AXI arbiter. Read and write paths each hold one
// transaction at a time and keep their grant from address to last data/response.
module axi_rr_arbiter
    import axi_rr_arbiter_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk_i,
    input logic              rst_n_i,
    axi_rr_arbiter_if.slave  m,
    axi_rr_arbiter_if.master s
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    rd_state_t        rd_state;
    wr_state_t        wr_state;
    logic [IDX_W-1:0] rd_gnt, wr_gnt, rd_pick, wr_pick;
    logic [NUM_M-1:0] rd_pick_oh, wr_pick_oh;
    logic             aw_done, w_done;
    logic             rd_done, wr_done, aw_hs, wl_hs;

    assign rd_done = (rd_state == RD_DATA) && s.rvalid && s.rready && s.rlast;
    assign wr_done = (wr_state == WR_RESP) && s.bvalid && s.bready;
    assign aw_hs   = s.awvalid && s.awready;
    assign wl_hs   = s.wvalid && s.wready && s.wlast;
    assign rd_pick = IDX_W'(onehot_idx(8'(rd_pick_oh)));
    assign wr_pick = IDX_W'(onehot_idx(8'(wr_pick_oh)));

    rr_arb #(.N(NUM_M), .IDX_W(IDX_W)) u_rd_arb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req(m.arvalid),
        .adv(rd_done), .adv_idx(rd_gnt), .gnt(rd_pick_oh)
    );

    rr_arb #(.N(NUM_M), .IDX_W(IDX_W)) u_wr_arb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req(m.awvalid),
        .adv(wr_done), .adv_idx(wr_gnt), .gnt(wr_pick_oh)
    );

    // Read FSM: latch the grant, forward AR, then route R until the last beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: if (|m.arvalid) begin
                    rd_gnt   <= rd_pick;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (s.arvalid && s.arready) rd_state <= RD_DATA;
                RD_DATA: if (rd_done) rd_state <= RD_IDLE;
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: AW and W run concurrently; wait for both before taking B.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (|m.awvalid) begin
                    wr_gnt   <= wr_pick;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: begin
                    if ((aw_done || aw_hs) && (w_done || wl_hs)) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= WR_RESP;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || wl_hs;
                    end
                end
                WR_RESP: if (wr_done) wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read muxes: everything is zero unless the granted master owns the phase.
    always_comb begin
        s.arid    = '0;
        s.araddr  = '0;
        s.arlen   = '0;
        s.arsize  = '0;
        s.arburst = '0;
        s.arvalid = 1'b0;
        s.rready  = 1'b0;
        m.arready = '0;
        m.rid     = '0;
        m.rdata   = '0;
        m.rresp   = '0;
        m.rlast   = '0;
        m.rvalid  = '0;
        if (rd_state == RD_ADDR) begin
            s.arid            = m.arid[rd_gnt*ID_W +: ID_W];
            s.araddr          = m.araddr[rd_gnt*ADDR_W +: ADDR_W];
            s.arlen           = m.arlen[rd_gnt*LEN_W +: LEN_W];
            s.arsize          = m.arsize[rd_gnt*SIZE_W +: SIZE_W];
            s.arburst         = m.arburst[rd_gnt*BURST_W +: BURST_W];
            s.arvalid         = m.arvalid[rd_gnt];
            m.arready[rd_gnt] = s.arready;
        end
        if (rd_state == RD_DATA) begin
            m.rid[rd_gnt*ID_W +: ID_W]       = s.rid;
            m.rdata[rd_gnt*DATA_W +: DATA_W] = s.rdata;
            m.rresp[rd_gnt*RESP_W +: RESP_W] = s.rresp;
            m.rlast[rd_gnt]                  = s.rlast;
            m.rvalid[rd_gnt]                 = s.rvalid;
            s.rready                         = m.rready[rd_gnt];
        end
    end

    // Write muxes: AW/W handshakes are masked once their done flag is set.
    always_comb begin
        s.awid    = '0;
        s.awaddr  = '0;
        s.awlen   = '0;
        s.awsize  = '0;
        s.awburst = '0;
        s.awvalid = 1'b0;
        s.wdata   = '0;
        s.wstrb   = '0;
        s.wlast   = 1'b0;
        s.wvalid  = 1'b0;
        s.bready  = 1'b0;
        m.awready = '0;
        m.wready  = '0;
        m.bid     = '0;
        m.bresp   = '0;
        m.bvalid  = '0;
        if (wr_state == WR_ADDR) begin
            s.awid            = m.awid[wr_gnt*ID_W +: ID_W];
            s.awaddr          = m.awaddr[wr_gnt*ADDR_W +: ADDR_W];
            s.awlen           = m.awlen[wr_gnt*LEN_W +: LEN_W];
            s.awsize          = m.awsize[wr_gnt*SIZE_W +: SIZE_W];
            s.awburst         = m.awburst[wr_gnt*BURST_W +: BURST_W];
            s.awvalid         = m.awvalid[wr_gnt] && !aw_done;
            m.awready[wr_gnt] = s.awready && !aw_done;
            s.wdata           = m.wdata[wr_gnt*DATA_W +: DATA_W];
            s.wstrb           = m.wstrb[wr_gnt*STRB_W +: STRB_W];
            s.wlast           = m.wlast[wr_gnt];
            s.wvalid          = m.wvalid[wr_gnt] && !w_done;
            m.wready[wr_gnt]  = s.wready && !w_done;
        end
        if (wr_state == WR_RESP) begin
            m.bid[wr_gnt*ID_W +: ID_W]       = s.bid;
            m.bresp[wr_gnt*RESP_W +: RESP_W] = s.bresp;
            m.bvalid[wr_gnt]                 = s.bvalid;
            s.bready                         = m.bready[wr_gnt];
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter with three masters.
module tb_axi_rr_arbiter;
    import axi_rr_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    axi_rr_arbiter_if #(.N(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) mi ();
    axi_rr_arbiter_if #(.N(1), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) si ();

    axi_rr_arbiter #(.NUM_M(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .m(mi), .s(si)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mi.arid = '0; mi.araddr = '0; mi.arlen = '0; mi.arsize = '0; mi.arburst = '0;
        mi.arvalid = '0; mi.rready = '0;
        mi.awid = '0; mi.awaddr = '0; mi.awlen = '0; mi.awsize = '0; mi.awburst = '0;
        mi.awvalid = '0; mi.wdata = '0; mi.wstrb = '0; mi.wlast = '0; mi.wvalid = '0;
        mi.bready = '0;
        si.arready = '0; si.rid = '0; si.rdata = '0; si.rresp = '0; si.rlast = '0;
        si.rvalid = '0; si.awready = '0; si.wready = '0; si.bid = '0; si.bresp = '0;
        si.bvalid = '0;
    endtask

    task automatic set_ar(input int k, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
        mi.arid[k*IW +: IW]     = id;
        mi.araddr[k*AW +: AW]   = addr;
        mi.arlen[k*8 +: 8]      = len;
        mi.arsize[k*3 +: 3]     = 3'd2;
        mi.arburst[k*2 +: 2]    = BURST_INCR;
        mi.arvalid[k]           = 1'b1;
    endtask

    task automatic set_aw(input int k, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        mi.awid[k*IW +: IW]     = id;
        mi.awaddr[k*AW +: AW]   = addr;
        mi.awlen[k*8 +: 8]      = 8'd0;
        mi.awsize[k*3 +: 3]     = 3'd2;
        mi.awburst[k*2 +: 2]    = BURST_INCR;
        mi.awvalid[k]           = 1'b1;
        mi.wdata[k*DW +: DW]    = data;
        mi.wstrb[k*4 +: 4]      = 4'hF;
        mi.wlast[k]             = 1'b1;
        mi.wvalid[k]            = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        for (int k = 0; k < N; k++) begin
            set_ar(k, IW'(k + 1), AW'(32'h1000 * (k + 1)), 8'd0);
            set_aw(k, IW'(k + 8), AW'(32'h8000 + k), DW'(32'h5A5A0000 + k));
        end
        mi.rready = '1; mi.bready = '1;
        si.arready = 1'b1; si.awready = 1'b1; si.wready = 1'b1;
        si.rvalid = 1'b1; si.rlast = 1'b1; si.rdata = '1; si.rid = '1; si.rresp = 2'b11;
        si.bvalid = 1'b1; si.bid = '1; si.bresp = 2'b11;
        tick();
        tick();
        total++;
        if ({si.arvalid, si.awvalid, si.wvalid, si.rready, si.bready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_s_ctl got=%b exp=0",
                     {si.arvalid, si.awvalid, si.wvalid, si.rready, si.bready});
        end
        total++;
        if ({mi.arready, mi.rvalid, mi.awready, mi.wready, mi.bvalid} !== 15'b0) begin
            bad++;
            $display("FAIL reset_m_ctl got=%b exp=0",
                     {mi.arready, mi.rvalid, mi.awready, mi.wready, mi.bvalid});
        end
        total++;
        if ((|{si.arid, si.araddr, si.arlen, si.awid, si.awaddr, si.wdata, si.wstrb, si.wlast})
            !== 1'b0) begin
            bad++;
            $display("FAIL reset_s_payload got=nonzero exp=0");
        end
        total++;
        if ((|{mi.rid, mi.rdata, mi.rresp, mi.rlast, mi.bid, mi.bresp}) !== 1'b0) begin
            bad++;
            $display("FAIL reset_m_payload got=nonzero exp=0");
        end
        rst_n = 1'b1;
        mi.awvalid = '0; mi.wvalid = '0;
        si.arready = 1'b0; si.rvalid = 1'b0; si.bvalid = 1'b0;
        #1;
        total++;
        if (si.arvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_early got=%b exp=0", si.arvalid);
        end
        tick();
        total++;
        if ({si.arvalid, si.arid, si.araddr} !== {1'b1, 4'h1, 32'h1000}) begin
            bad++;
            $display("FAIL reset_first_grant got=%b/%h/%h exp=1/1/00001000",
                     si.arvalid, si.arid, si.araddr);
        end
    endtask

    task automatic test_round_robin();
        int order[4];
        int g;
        order = '{0, 1, 2, 0};
        do_reset();
        for (int k = 0; k < N; k++) set_ar(k, IW'(k + 1), AW'(32'h100 * (k + 1)), 8'd0);
        mi.rready = '1;
        si.arready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            g = order[n];
            tick();
            total++;
            if ({si.arvalid, si.arid} !== {1'b1, IW'(g + 1)}) begin
                bad++;
                $display("FAIL rr_grant n=%0d got=%b/%h exp=1/%h", n, si.arvalid, si.arid, g + 1);
            end
            tick();
            si.rvalid = 1'b1; si.rlast = 1'b1; si.rid = IW'(g + 1);
            si.rdata = DW'(32'hC0DE0000 + g);
            #1;
            total++;
            if (mi.rvalid !== 3'(1 << g)) begin
                bad++;
                $display("FAIL rr_rvalid n=%0d got=%b exp=%b", n, mi.rvalid, 3'(1 << g));
            end
            total++;
            if (mi.rdata[g*DW +: DW] !== DW'(32'hC0DE0000 + g)) begin
                bad++;
                $display("FAIL rr_rdata n=%0d got=%h exp=%h", n, mi.rdata[g*DW +: DW],
                         32'hC0DE0000 + g);
            end
            tick();
            si.rvalid = 1'b0; si.rlast = 1'b0;
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        set_ar(0, 4'h5, 32'h2000, 8'd3);
        mi.rready = '1;
        si.arready = 1'b1;
        tick();
        tick();
        mi.arvalid[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            si.rvalid = 1'b1; si.rlast = (b == 3); si.rdata = DW'(32'hB0 + b);
            #1;
            total++;
            if (mi.rvalid !== 3'b001) begin
                bad++;
                $display("FAIL lock_rvalid beat=%0d got=%b exp=001", b, mi.rvalid);
            end
            total++;
            if (si.arvalid !== 1'b0) begin
                bad++;
                $display("FAIL lock_no_ar beat=%0d got=%b exp=0", b, si.arvalid);
            end
            tick();
            if (b == 1) set_ar(1, 4'h6, 32'h3000, 8'd0);
        end
        si.rvalid = 1'b0; si.rlast = 1'b0;
        #1;
        total++;
        if (si.arvalid !== 1'b0) begin
            bad++;
            $display("FAIL lock_idle_gap got=%b exp=0", si.arvalid);
        end
        tick();
        total++;
        if ({si.arvalid, si.arid} !== {1'b1, 4'h6}) begin
            bad++;
            $display("FAIL lock_next_grant got=%b/%h exp=1/6", si.arvalid, si.arid);
        end
    endtask

    task automatic test_write_order();
        do_reset();
        set_aw(1, 4'h7, 32'h4000, 32'h12345678);
        mi.bready = '1;
        si.awready = 1'b0; si.wready = 1'b1;
        tick();
        total++;
        if ({si.awvalid, si.wvalid, si.awid, si.wdata} !== {1'b1, 1'b1, 4'h7, 32'h12345678}) begin
            bad++;
            $display("FAIL wr_fwd got=%b/%b/%h/%h exp=1/1/7/12345678",
                     si.awvalid, si.wvalid, si.awid, si.wdata);
        end
        total++;
        if ({mi.awready, mi.wready} !== {3'b000, 3'b010}) begin
            bad++;
            $display("FAIL wr_ready_first got=%b/%b exp=000/010", mi.awready, mi.wready);
        end
        tick();
        si.awready = 1'b1;
        #1;
        total++;
        if ({si.wvalid, mi.wready} !== 4'b0) begin
            bad++;
            $display("FAIL wr_w_masked got=%b/%b exp=0/000", si.wvalid, mi.wready);
        end
        total++;
        if (mi.awready !== 3'b010) begin
            bad++;
            $display("FAIL wr_awready got=%b exp=010", mi.awready);
        end
        tick();
        mi.awvalid[1] = 1'b0; mi.wvalid[1] = 1'b0;
        si.awready = 1'b0;
        si.bvalid = 1'b1; si.bid = 4'h7; si.bresp = RESP_OKAY;
        #1;
        total++;
        if (mi.bvalid !== 3'b010) begin
            bad++;
            $display("FAIL wr_bvalid got=%b exp=010", mi.bvalid);
        end
        total++;
        if ({si.bready, mi.bid} !== {1'b1, 12'h070}) begin
            bad++;
            $display("FAIL wr_bid got=%b/%h exp=1/070", si.bready, mi.bid);
        end
        tick();
        si.bvalid = 1'b0;
        #1;
        total++;
        if (mi.bvalid !== 3'b000) begin
            bad++;
            $display("FAIL wr_b_done got=%b exp=000", mi.bvalid);
        end
        total++;
        if (dut.u_wr_arb.ptr !== 2'd2) begin
            bad++;
            $display("FAIL wr_ptr got=%0d exp=2", dut.u_wr_arb.ptr);
        end
    endtask

    task automatic test_concurrency();
        do_reset();
        set_aw(0, 4'h9, 32'h5000, 32'h0BADF00D);
        set_ar(1, 4'hA, 32'h6000, 8'd0);
        mi.rready = '1; mi.bready = '1;
        si.arready = 1'b1; si.awready = 1'b1; si.wready = 1'b1;
        tick();
        total++;
        if ({si.arvalid, si.arid, si.awvalid, si.awid} !== {1'b1, 4'hA, 1'b1, 4'h9}) begin
            bad++;
            $display("FAIL cc_addr got=%b/%h/%b/%h exp=1/a/1/9",
                     si.arvalid, si.arid, si.awvalid, si.awid);
        end
        tick();
        mi.arvalid = '0; mi.awvalid = '0; mi.wvalid = '0;
        si.rvalid = 1'b1; si.rlast = 1'b1; si.rid = 4'hA; si.rdata = 32'hDEADBEEF;
        si.bvalid = 1'b1; si.bid = 4'h9; si.bresp = RESP_OKAY;
        #1;
        total++;
        if ({mi.rvalid, mi.rdata} !== {3'b010, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            bad++;
            $display("FAIL cc_read got=%b/%h exp=010/00000000deadbeef00000000",
                     mi.rvalid, mi.rdata);
        end
        total++;
        if ({mi.bvalid, mi.bid, mi.bresp} !== {3'b001, 12'h009, 6'b0}) begin
            bad++;
            $display("FAIL cc_bresp got=%b/%h/%b exp=001/009/000000",
                     mi.bvalid, mi.bid, mi.bresp);
        end
        tick();
        si.rvalid = 1'b0; si.rlast = 1'b0; si.bvalid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_ar(0, 4'h3, 32'h7000, 8'd3);
        mi.rready = '1;
        si.arready = 1'b1;
        tick();
        tick();
        mi.arvalid[0] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            si.rvalid = 1'b1; si.rdata = DW'(32'hE0 + b);
            tick();
        end
        si.rvalid = 1'b1; si.rdata = 32'hE2;
        #1;
        total++;
        if (mi.rvalid !== 3'b001) begin
            bad++;
            $display("FAIL arst_pre got=%b exp=001", mi.rvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mi.rvalid, si.rready, si.arvalid} !== 5'b0) begin
            bad++;
            $display("FAIL arst_out got=%b/%b/%b exp=000/0/0", mi.rvalid, si.rready, si.arvalid);
        end
        total++;
        if ((|mi.rdata) !== 1'b0) begin
            bad++;
            $display("FAIL arst_payload got=%h exp=0", mi.rdata);
        end
        si.rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        set_ar(0, 4'h4, 32'h7100, 8'd0);
        set_ar(2, 4'hC, 32'h7200, 8'd0);
        tick();
        total++;
        if ({si.arvalid, si.arid, si.araddr} !== {1'b1, 4'h4, 32'h7100}) begin
            bad++;
            $display("FAIL arst_regrant got=%b/%h/%h exp=1/4/00007100",
                     si.arvalid, si.arid, si.araddr);
        end
        tick();
        mi.arvalid = '0;
        si.rvalid = 1'b1; si.rlast = 1'b1; si.rid = 4'h4; si.rdata = 32'h600D;
        #1;
        total++;
        if ({mi.rvalid, mi.rdata[DW-1:0]} !== {3'b001, 32'h600D}) begin
            bad++;
            $display("FAIL arst_fresh_read got=%b/%h exp=001/0000600d",
                     mi.rvalid, mi.rdata[DW-1:0]);
        end
        tick();
        si.rvalid = 1'b0; si.rlast = 1'b0;
        #1;
        total++;
        if (dut.u_rd_arb.ptr !== 2'd1) begin
            bad++;
            $display("FAIL arst_ptr got=%0d exp=1", dut.u_rd_arb.ptr);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_write_order();
        test_concurrency();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
